pwm_regbank: RTL and testbench

Register bank and multi-channel PWM generator directly downstream of the SPI slave.
- Consumes the SPI slave's address/write-data/write-enable outputs and supplies the read-data byte it shifts out on MISO.
- Registers configure a shared prescaler and period counter and per-channel duty values.
- Drives NUM_CH PWM output pins with glitch-free, double-buffered duty updates.

---
 rtl/pwm_regbank_pkg.sv | 18 +
 rtl/pwm_regbank_channel.sv | 33 +++
 rtl/pwm_regbank.sv | 130 +++++++++++++
 tb/tb_pwm_regbank.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_regbank_pkg.sv
// Shared register map, control-bit positions and reset values for the PWM register bank.
package pwm_regbank_pkg;

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_PRESC  = 8'h01;
    localparam logic [7:0] ADDR_PERIOD = 8'h02;
    localparam logic [7:0] ADDR_DUTY0  = 8'h04;
    localparam logic [7:0] ADDR_STATUS = 8'h10;
    localparam logic [7:0] ADDR_ID     = 8'h7F;

    localparam int CTRL_RUN_BIT = 7;

    localparam logic [7:0] RST_CTRL   = 8'h00;
    localparam logic [7:0] RST_PRESC  = 8'h00;
    localparam logic [7:0] RST_PERIOD = 8'hFF;
    localparam logic [7:0] RST_DUTY   = 8'h00;

endpackage

// File: rtl/pwm_regbank_channel.sv
// One PWM channel: double-buffered duty (shadow written by software, active used for compare)
// and the registered compare output.
module pwm_channel
    import pwm_regbank_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_stb,
    input  logic [7:0] wr_data,
    input  logic       wrap,
    input  logic       run,
    input  logic       enable,
    input  logic [7:0] cnt,
    output logic [7:0] duty_shadow,
    output logic       pwm_out
);

    logic [7:0] duty_active;

    // Active duty only moves at a wrap (or while stopped), so a running period is never cut short.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            duty_shadow <= RST_DUTY;
            duty_active <= RST_DUTY;
            pwm_out     <= 1'b0;
        end else begin
            if (wr_stb) duty_shadow <= wr_data;
            if (!run || wrap) duty_active <= duty_shadow;
            pwm_out <= run && enable && (cnt < duty_active);
        end
    end

endmodule

// File: rtl/pwm_regbank.sv
// SPI-facing register bank driving NUM_CH PWM outputs from a shared prescaler/period counter.
// Optional macro PWM_IRQ_EN adds the STATUS register (wrap flag + mask) and the irq output.
module pwm_regbank
    import pwm_regbank_pkg::*;
#(
    parameter int         NUM_CH   = 4,
    parameter logic [7:0] ID_VALUE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        addr,
    input  logic [7:0]        wr_data,
    input  logic              wr_en,
    output logic [7:0]        rd_data,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              irq
);

    localparam logic [7:0] CTRL_MASK = 8'h80 | 8'((1 << NUM_CH) - 1);

    logic       wr_en_q;
    logic       commit;
    logic [7:0] ctrl;
    logic [7:0] presc;
    logic [7:0] period;
    logic [7:0] presc_cnt;
    logic [7:0] cnt;
    logic       run;
    logic       tick;
    logic       wrap;
    logic [7:0] status;
    logic [7:0] duty_shadow [NUM_CH];

    // wr_en is a level from the SPI slave; only its rising edge commits a write.
    assign commit = wr_en & ~wr_en_q;
    assign run    = ctrl[CTRL_RUN_BIT];
    assign tick   = run && (presc_cnt >= presc);
    assign wrap   = tick && (cnt >= period);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en_q <= 1'b0;
            ctrl    <= RST_CTRL;
            presc   <= RST_PRESC;
            period  <= RST_PERIOD;
        end else begin
            wr_en_q <= wr_en;
            if (commit) begin
                case (addr)
                    ADDR_CTRL:   ctrl   <= wr_data & CTRL_MASK;
                    ADDR_PRESC:  presc  <= wr_data;
                    ADDR_PERIOD: period <= wr_data;
                    default: ;
                endcase
            end
        end
    end

    // >= comparisons let a lowered PERIOD/PRESC wrap on the next tick instead of running to 255.
    always_ff @(posedge clk) begin
        if (!rst_n || !run) begin
            presc_cnt <= 8'h00;
            cnt       <= 8'h00;
        end else begin
            presc_cnt <= tick ? 8'h00 : presc_cnt + 8'h01;
            if (tick) cnt <= wrap ? 8'h00 : cnt + 8'h01;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_channel u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .wr_stb      (commit && (addr == ADDR_DUTY0 + 8'(i))),
            .wr_data     (wr_data),
            .wrap        (wrap),
            .run         (run),
            .enable      (ctrl[i]),
            .cnt         (cnt),
            .duty_shadow (duty_shadow[i]),
            .pwm_out     (pwm_out[i])
        );
    end

`ifdef PWM_IRQ_EN
    logic status_flag;
    logic status_mask;
    logic irq_q;

    // A wrap on the same cycle as a clearing write keeps the flag set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            status_flag <= 1'b0;
            status_mask <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            if (wrap) begin
                status_flag <= 1'b1;
            end else if (commit && (addr == ADDR_STATUS) && wr_data[0]) begin
                status_flag <= 1'b0;
            end
            if (commit && (addr == ADDR_STATUS)) status_mask <= wr_data[1];
            irq_q <= status_flag & status_mask;
        end
    end

    assign status = {6'b0, status_mask, status_flag};
    assign irq    = irq_q;
`else
    assign status = 8'h00;
    assign irq    = 1'b0;
`endif

    // Pure decode of addr so the byte stays stable while the SPI slave shifts it out.
    always_comb begin
        rd_data = 8'h00;
        case (addr)
            ADDR_CTRL:   rd_data = ctrl;
            ADDR_PRESC:  rd_data = presc;
            ADDR_PERIOD: rd_data = period;
            ADDR_STATUS: rd_data = status;
            ADDR_ID:     rd_data = ID_VALUE;
            default: ;
        endcase
        for (int i = 0; i < NUM_CH; i++) begin
            if (addr == ADDR_DUTY0 + 8'(i)) rd_data = duty_shadow[i];
        end
    end

endmodule

// File: tb/tb_pwm_regbank.sv
// Bench for pwm_regbank: register vector table plus waveform sequences, checked through a scoreboard queue.
module tb_pwm_regbank;

    localparam int NUM_CH = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        addr;
    logic [7:0]        wr_data;
    logic              wr_en;
    logic [7:0]        rd_data;
    logic [NUM_CH-1:0] pwm_out;
    logic              irq;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic       wr;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs [13];

    logic [19:0] pat [4];

    always #5 clk = ~clk;

    pwm_regbank #(.NUM_CH(NUM_CH), .ID_VALUE(8'hA5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr    (addr),
        .wr_data (wr_data),
        .wr_en   (wr_en),
        .rd_data (rd_data),
        .pwm_out (pwm_out),
        .irq     (irq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string name, input logic [31:0] exp);
        sb_t e;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic compare(input logic [31:0] act);
        sb_t e;
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty got=0x%0h", act);
        end else begin
            e = sb_q.pop_front();
            if (act !== e.exp) begin
                bad++;
                $display("FAIL %s got=0x%0h want=0x%0h", e.name, act, e.exp);
            end
        end
    endtask

    task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
        addr    = a;
        wr_data = d;
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
        tick();
    endtask

    task automatic read_check(input string name, input logic [7:0] a, input logic [7:0] exp);
        addr = a;
        expect_val(name, 32'(exp));
        #1;
        compare(32'(rd_data));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 8'h7F, 8'h00, 8'hA5};
        vecs[1]  = '{1'b0, 8'h02, 8'h00, 8'hFF};
        vecs[2]  = '{1'b0, 8'h00, 8'h00, 8'h00};
        vecs[3]  = '{1'b0, 8'h01, 8'h00, 8'h00};
        vecs[4]  = '{1'b0, 8'h03, 8'h00, 8'h00};
        vecs[5]  = '{1'b1, 8'h01, 8'h5A, 8'h5A};
        vecs[6]  = '{1'b1, 8'h00, 8'h7F, 8'h0F};
        vecs[7]  = '{1'b1, 8'h00, 8'h00, 8'h00};
        vecs[8]  = '{1'b1, 8'h07, 8'h33, 8'h33};
        vecs[9]  = '{1'b1, 8'h08, 8'h44, 8'h00};
        vecs[10] = '{1'b1, 8'h7F, 8'h00, 8'hA5};
        vecs[11] = '{1'b1, 8'h05, 8'h81, 8'h81};
        vecs[12] = '{1'b1, 8'h10, 8'h01, 8'h00};

        rst_n   = 1'b0;
        wr_en   = 1'b0;
        addr    = 8'h00;
        wr_data = 8'h00;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        expect_val("reset_pwm", 32'h0);
        compare(32'(pwm_out));
        expect_val("reset_irq", 32'h0);
        compare(32'(irq));

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].wr) write_reg(vecs[i].a, vecs[i].d);
            read_check($sformatf("vec%0d_addr%0h", i, vecs[i].a), vecs[i].a, vecs[i].exp);
        end

        // Held wr_en with changing data must commit only the first value.
        addr    = 8'h04;
        wr_data = 8'h10;
        wr_en   = 1'b1;
        expect_val("held_before_edge", 32'h00);
        #1;
        compare(32'(rd_data));
        tick();
        expect_val("held_after_commit", 32'h10);
        compare(32'(rd_data));
        wr_data = 8'h22;
        repeat (19) tick();
        wr_en = 1'b0;
        tick();
        read_check("held_single_commit", 8'h04, 8'h10);

        // PRESC=1, PERIOD=9, DUTY0=3: 6 high / 14 low per 20-clk period.
        write_reg(8'h01, 8'h01);
        write_reg(8'h02, 8'h09);
        write_reg(8'h04, 8'h03);
        write_reg(8'h00, 8'h81);
        for (int k = 0; k < 3; k++) expect_val($sformatf("wave_period%0d", k), 32'h0003F);
        for (int n = 1; n <= 60; n++) begin
            if (n > 1) tick();
            pat[(n - 1) / 20][(n - 1) % 20] = pwm_out[0];
        end
        for (int k = 0; k < 3; k++) compare(32'(pat[k]));
        expect_val("irq_masked", 32'h0);
        compare(32'(irq));

        // Mid-period DUTY0=7, then DUTY0=2 written on the very wrap edge.
        expect_val("mid_keep_old", 32'h0003F);
        expect_val("mid_new_duty", 32'h03FFF);
        expect_val("wrap_write_old", 32'h03FFF);
        expect_val("wrap_write_new", 32'h0000F);
        for (int n = 61; n <= 140; n++) begin
            if (n == 63) begin addr = 8'h04; wr_data = 8'h07; wr_en = 1'b1; end
            if (n == 64) wr_en = 1'b0;
            if (n == 100) begin addr = 8'h04; wr_data = 8'h02; wr_en = 1'b1; end
            if (n == 101) wr_en = 1'b0;
            tick();
            pat[(n - 61) / 20][(n - 61) % 20] = pwm_out[0];
        end
        for (int k = 0; k < 4; k++) compare(32'(pat[k]));
        read_check("duty0_shadow", 8'h04, 8'h02);

        // DUTY1=0 stays low, DUTY2=0xFF > PERIOD stays high, disabled channels low.
        write_reg(8'h00, 8'h00);
        write_reg(8'h05, 8'h00);
        write_reg(8'h06, 8'hFF);
        write_reg(8'h00, 8'h86);
        begin
            int errs = 0;
            for (int n = 0; n < 40; n++) begin
                if (n > 0) tick();
                if (pwm_out !== 4'b0100) errs++;
            end
            expect_val("duty_edge_cycles_wrong", 32'h0);
            compare(32'(errs));
        end

        write_reg(8'h00, 8'h06);
        expect_val("stopped_pwm", 32'h0);
        compare(32'(pwm_out));

        // Lowering PERIOD below the running count must wrap, not count up to 255.
        write_reg(8'h01, 8'h00);
        write_reg(8'h02, 8'h09);
        write_reg(8'h04, 8'h03);
        write_reg(8'h00, 8'h81);
        repeat (6) tick();
        write_reg(8'h02, 8'h02);
        repeat (2) tick();
        expect_val("period_lowered", 32'hFFFFF);
        for (int n = 0; n < 20; n++) begin
            if (n > 0) tick();
            pat[0][n] = pwm_out[0];
        end
        compare(32'(pat[0]));

`ifdef PWM_IRQ_EN
        write_reg(8'h00, 8'h00);
        write_reg(8'h10, 8'h02);
        write_reg(8'h02, 8'h03);
        write_reg(8'h00, 8'h80);
        begin
            int w = 0;
            while (!irq && w < 20) begin
                tick();
                w++;
            end
        end
        expect_val("irq_rise", 32'h1);
        compare(32'(irq));
        read_check("status_set", 8'h10, 8'h03);
        write_reg(8'h00, 8'h00);
        write_reg(8'h10, 8'h03);
        expect_val("irq_clear", 32'h0);
        compare(32'(irq));
        read_check("status_cleared", 8'h10, 8'h02);
        write_reg(8'h00, 8'h81);
        repeat (10) tick();
`endif

        // Reset while running: everything back to reset values on the next clk.
        rst_n = 1'b0;
        tick();
        expect_val("midrun_reset_pwm", 32'h0);
        compare(32'(pwm_out));
        expect_val("midrun_reset_irq", 32'h0);
        compare(32'(irq));
        rst_n = 1'b1;
        read_check("midrun_reset_period", 8'h02, 8'hFF);
        read_check("midrun_reset_ctrl", 8'h00, 8'h00);
        read_check("midrun_reset_duty0", 8'h04, 8'h00);
        read_check("midrun_reset_presc", 8'h01, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
